// File: rtl/log_lane_if.sv
// log_lane_if: pixel, frame-strobe and sprite-ROM signals shared by a log lane and its driver.
interface log_lane_if;
  logic        frame_clk;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [3:0]  rom_data;
  logic [11:0] rom_addr;
  logic        log_on;
  logic [3:0]  log_index;
  logic        move_pulse;
  logic [9:0]  log_x0;
  modport master (
    output frame_clk, DrawX, DrawY, rom_data,
    input  rom_addr, log_on, log_index, move_pulse, log_x0
  );
  modport slave (
    input  frame_clk, DrawX, DrawY, rom_data,
    output rom_addr, log_on, log_index, move_pulse, log_x0
  );
endinterface

// File: rtl/log_lane.sv
// log_lane: one lane of evenly spaced scrolling logs; steps the offset every FRAME_DIV frames
// and renders through a 3-stage pipeline around the 40x80 log sprite ROM.
module log_lane #(
  parameter int LANE_Y      = 200,
  parameter int NUM_LOGS    = 3,
  parameter int LOG_SPACING = 213,
  parameter int SPEED       = 1,
  parameter int DIR         = 0,
  parameter int FRAME_DIV   = 2
) (
  input logic       Clk,
  input logic       Reset_n,
  log_lane_if.slave bus
);
  logic                r_frame_q;
  logic [3:0]          r_cnt;
  logic [9:0]          r_offset;
  logic                r_move;
  logic [11:0]         r_rom_addr;
  logic                r_hit1;
  logic                r_hit2;
  logic                r_log_on;
  logic [3:0]          r_log_index;
  logic                w_frame_ev;
  logic                w_cnt_wrap;
  logic                w_step;
  logic [10:0]         w_inc;
  logic [9:0]          w_next_off;
  logic [9:0]          w_xk [NUM_LOGS];
  logic [9:0]          w_rx [NUM_LOGS];
  logic [NUM_LOGS-1:0] w_hk;
  logic                w_in_lane;
  logic                w_any;
  logic                w_hit;
  logic [9:0]          w_sel_x;
  logic [5:0]          w_rel_y;
  logic [11:0]         w_addr;
  logic                w_opaque;
  assign w_frame_ev = bus.frame_clk && !r_frame_q;
  assign w_cnt_wrap = r_cnt == 4'(FRAME_DIV - 1);
  assign w_step     = w_frame_ev && w_cnt_wrap;
  assign w_inc      = {1'b0, r_offset} + 11'(SPEED);
  assign w_next_off = DIR == 0
    ? (w_inc >= 11'd640 ? 10'(w_inc - 11'd640) : w_inc[9:0])
    : (r_offset < 10'(SPEED) ? 10'(r_offset + 10'(640 - SPEED)) : 10'(r_offset - 10'(SPEED)));
  genvar k;
  for (k = 0; k < NUM_LOGS; k++) begin : g_log
    // k*LOG_SPACING is folded into 0..639 at elaboration so one subtract suffices at run time
    localparam logic [10:0] KOFF = 11'((k * LOG_SPACING) % 640);
    logic [10:0] w_s;
    assign w_s     = {1'b0, r_offset} + KOFF;
    assign w_xk[k] = w_s >= 11'd640 ? 10'(w_s - 11'd640) : w_s[9:0];
    assign w_rx[k] = bus.DrawX >= w_xk[k] ? 10'(bus.DrawX - w_xk[k]) : 10'(bus.DrawX + 10'd640 - w_xk[k]);
    assign w_hk[k] = w_rx[k] < 10'd80;
  end
  assign w_in_lane = bus.DrawY >= 10'(LANE_Y) && bus.DrawY < 10'(LANE_Y + 40)
                  && bus.DrawX < 10'd640 && bus.DrawY < 10'd480;
  always_comb begin
    w_any   = 1'b0;
    w_sel_x = '0;
    for (int i = NUM_LOGS - 1; i >= 0; i--) begin
      w_any   = w_hk[i] ? 1'b1 : w_any;
      w_sel_x = w_hk[i] ? w_rx[i] : w_sel_x;
    end
  end
  assign w_hit    = w_in_lane && w_any;
  assign w_rel_y  = 6'(bus.DrawY - 10'(LANE_Y));
  assign w_addr   = 12'(w_rel_y) * 12'd80 + 12'(w_sel_x);
  assign w_opaque = r_hit2 && (bus.rom_data != 4'd0);
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_frame_q   <= 1'b0;
      r_cnt       <= '0;
      r_offset    <= '0;
      r_move      <= 1'b0;
      r_rom_addr  <= '0;
      r_hit1      <= 1'b0;
      r_hit2      <= 1'b0;
      r_log_on    <= 1'b0;
      r_log_index <= '0;
    end else begin
      r_frame_q   <= bus.frame_clk;
      r_cnt       <= w_frame_ev ? (w_cnt_wrap ? 4'd0 : 4'(r_cnt + 4'd1)) : r_cnt;
      r_offset    <= w_step ? w_next_off : r_offset;
      r_move      <= w_step;
      r_rom_addr  <= w_hit ? w_addr : 12'd0;
      r_hit1      <= w_hit;
      r_hit2      <= r_hit1;
      r_log_on    <= w_opaque;
      r_log_index <= w_opaque ? bus.rom_data : 4'd0;
    end
  end
  assign bus.rom_addr   = r_rom_addr;
  assign bus.log_on     = r_log_on;
  assign bus.log_index  = r_log_index;
  assign bus.move_pulse = r_move;
  assign bus.log_x0     = r_offset;
endmodule

// File: tb/tb_log_lane.sv
// tb_log_lane: directed vectors and hand-written sequences for a rightward and a leftward lane.
module tb_log_lane;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   p0 = 0;
  log_lane_if bus0();
  log_lane_if bus1();
  log_lane u0 (.Clk(clk), .Reset_n(rst_n), .bus(bus0.slave));
  log_lane #(.SPEED(3), .DIR(1)) u1 (.Clk(clk), .Reset_n(rst_n), .bus(bus1.slave));
  always #5 clk = ~clk;
  function automatic logic [3:0] rom_fn(input logic [11:0] a);
    return a[3:0];
  endfunction
  always @(posedge clk) bus0.rom_data <= rom_fn(bus0.rom_addr);
  always @(negedge clk) if (bus0.move_pulse === 1'b1) p0++;
  typedef struct {
    int x;
    int y;
    int addr;
    int on;
    int idx;
  } vec_t;
  vec_t tv[10];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic frame(input int which, input int hold);
    @(negedge clk);
    if (which == 0) bus0.frame_clk = 1'b1; else bus1.frame_clk = 1'b1;
    repeat (hold) @(negedge clk);
    if (which == 0) bus0.frame_clk = 1'b0; else bus1.frame_clk = 1'b0;
    @(negedge clk);
  endtask
  task automatic run_vec(input int n);
    @(negedge clk);
    bus0.DrawX = 10'd700;
    bus0.DrawY = 10'd200;
    repeat (3) @(negedge clk);
    bus0.DrawX = 10'(tv[n].x);
    bus0.DrawY = 10'(tv[n].y);
    @(posedge clk); #1;
    chk($sformatf("v%0d rom_addr", n), 32'(bus0.rom_addr), 32'(tv[n].addr));
    @(posedge clk); #1;
    chk($sformatf("v%0d early log_on", n), 32'(bus0.log_on), 32'd0);
    @(posedge clk); #1;
    chk($sformatf("v%0d log_on", n), 32'(bus0.log_on), 32'(tv[n].on));
    chk($sformatf("v%0d log_index", n), 32'(bus0.log_index), 32'(tv[n].idx));
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int p_start;
    // offset 600: logs at 600, 173, 386; ROM returns addr[3:0]
    tv[0] = '{10, 200, 50, 1, 2};
    tv[1] = '{40, 200, 0, 0, 0};
    tv[2] = '{600, 201, 80, 0, 0};
    tv[3] = '{607, 200, 7, 1, 7};
    tv[4] = '{175, 203, 242, 1, 2};
    tv[5] = '{639, 239, 3159, 1, 7};
    tv[6] = '{10, 240, 0, 0, 0};
    tv[7] = '{10, 199, 0, 0, 0};
    tv[8] = '{700, 200, 0, 0, 0};
    tv[9] = '{400, 220, 1614, 1, 14};
    bus0.frame_clk = 1'b0;
    bus0.DrawX = 10'd5;
    bus0.DrawY = 10'd202;
    bus1.frame_clk = 1'b0;
    bus1.DrawX = 10'd0;
    bus1.DrawY = 10'd0;
    bus1.rom_data = 4'd0;
    repeat (6) @(negedge clk) bus0.frame_clk = ~bus0.frame_clk;
    chk("reset log_x0", 32'(bus0.log_x0), 32'd0);
    chk("reset rom_addr", 32'(bus0.rom_addr), 32'd0);
    chk("reset log_on", 32'(bus0.log_on), 32'd0);
    chk("reset log_index", 32'(bus0.log_index), 32'd0);
    chk("reset move_pulse", 32'(bus0.move_pulse), 32'd0);
    bus0.frame_clk = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-reset rom_addr", 32'(bus0.rom_addr), 32'd165);
    @(posedge clk); #1;
    chk("post-reset early log_on", 32'(bus0.log_on), 32'd0);
    @(posedge clk); #1;
    chk("post-reset log_on", 32'(bus0.log_on), 32'd1);
    chk("post-reset log_index", 32'(bus0.log_index), 32'd5);
    p_start = p0;
    frame(0, 1);
    chk("one frame log_x0", 32'(bus0.log_x0), 32'd0);
    for (int i = 1; i < 10; i++) frame(0, (i % 2 == 1) ? 12 : 1);
    chk("ten frames pulses", 32'(p0 - p_start), 32'd5);
    chk("ten frames log_x0", 32'(bus0.log_x0), 32'd5);
    repeat (1190) frame(0, 1);
    chk("offset 600", 32'(bus0.log_x0), 32'd600);
    for (int i = 0; i < 10; i++) run_vec(i);
    repeat (78) frame(0, 1);
    chk("offset 639", 32'(bus0.log_x0), 32'd639);
    repeat (2) frame(0, 1);
    chk("right wrap log_x0", 32'(bus0.log_x0), 32'd0);
    // flush the pipeline with an asynchronous reset while a hit is in flight
    @(negedge clk);
    bus0.DrawX = 10'd5;
    bus0.DrawY = 10'd202;
    repeat (3) @(posedge clk);
    #1 chk("pre-flush log_on", 32'(bus0.log_on), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("flush log_on", 32'(bus0.log_on), 32'd0);
    chk("flush rom_addr", 32'(bus0.rom_addr), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("flush early log_on", 32'(bus0.log_on), 32'd0);
    @(posedge clk); #1;
    chk("flush log_on restored", 32'(bus0.log_on), 32'd1);
    chk("flush log_index", 32'(bus0.log_index), 32'd5);
    repeat (2) frame(1, 1);
    chk("left first step", 32'(bus1.log_x0), 32'd637);
    repeat (424) frame(1, 1);
    chk("left offset 1", 32'(bus1.log_x0), 32'd1);
    repeat (2) frame(1, 1);
    chk("left wrap log_x0", 32'(bus1.log_x0), 32'd638);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
